// File: rtl/object_bank_pkg.sv
// Shared types and helpers for the object_bank animator: FSM encoding,
// legal centre-range derivation and velocity saturation.
package object_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_H_SIZE   = 10;
    localparam int DEF_V_SIZE   = 10;
    localparam int DEF_D_WIDTH  = 640;
    localparam int DEF_D_HEIGHT = 480;

    function automatic int axis_min(input int half);
        return half;
    endfunction

    function automatic int axis_max(input int disp, input int half);
        return disp - 1 - half;
    endfunction

    localparam int XMIN = axis_min(DEF_H_SIZE);
    localparam int XMAX = axis_max(DEF_D_WIDTH, DEF_H_SIZE);
    localparam int YMIN = axis_min(DEF_V_SIZE);
    localparam int YMAX = axis_max(DEF_D_HEIGHT, DEF_V_SIZE);

    // The most negative velocity has no positive twin, so it is pulled in by one.
    function automatic logic signed [31:0] sat_vel(input logic signed [31:0] v, input int step_w);
        logic signed [31:0] most_neg;
        most_neg = -(32'sd1 <<< (step_w - 1));
        return (v == most_neg) ? v + 32'sd1 : v;
    endfunction

endpackage

// File: rtl/object_axis_step.sv
// One-axis position step with clamp-and-negate reflection at the range limits.
module object_axis_step #(
    parameter int COORD_W = 12,
    parameter int STEP_W  = 5
) (
    input  logic        [COORD_W-1:0] in_p,
    input  logic signed [STEP_W-1:0]  in_v,
    input  logic        [COORD_W-1:0] in_min,
    input  logic        [COORD_W-1:0] in_max,
    output logic        [COORD_W-1:0] out_p,
    output logic signed [STEP_W-1:0]  out_v,
    output logic                      out_bounce
);

    localparam int W = COORD_W + 2;

    logic signed [W-1:0] n_sum;
    logic signed [W-1:0] lo;
    logic signed [W-1:0] hi;

    assign n_sum = $signed({2'b00, in_p}) + W'(in_v);
    assign lo    = $signed({2'b00, in_min});
    assign hi    = $signed({2'b00, in_max});

    always_comb begin
        out_p      = n_sum[COORD_W-1:0];
        out_v      = in_v;
        out_bounce = 1'b0;
        if (n_sum < lo) begin
            out_p      = in_min;
            out_v      = -in_v;
            out_bounce = 1'b1;
        end else if (n_sum > hi) begin
            out_p      = in_max;
            out_v      = -in_v;
            out_bounce = 1'b1;
        end
    end

endmodule

// File: rtl/object_bank.sv
// Holds N_OBJ rectangular objects and steps them one per clock after each
// honoured animation strobe; a processor write port loads object state.
module object_bank
    import object_bank_pkg::*;
#(
    parameter int N_OBJ    = 4,
    parameter int IDX_W    = (N_OBJ > 1) ? $clog2(N_OBJ) : 1,
    parameter int COORD_W  = 12,
    parameter int STEP_W   = 5,
    parameter int H_SIZE   = 10,
    parameter int V_SIZE   = 10,
    parameter int D_WIDTH  = 640,
    parameter int D_HEIGHT = 480
) (
    input  logic                       in_clock,
    input  logic                       in_reset_n,
    input  logic                       in_ani_stb,
    input  logic                       in_animate,
    input  logic                       in_cfg_we,
    input  logic [IDX_W-1:0]           in_cfg_idx,
    input  logic [COORD_W-1:0]         in_cfg_x,
    input  logic [COORD_W-1:0]         in_cfg_y,
    input  logic signed [STEP_W-1:0]   in_cfg_vx,
    input  logic signed [STEP_W-1:0]   in_cfg_vy,
    output logic                       out_busy,
    output logic                       out_frame_done,
    output logic [N_OBJ-1:0]           out_bounce,
    output logic                       out_overrun,
    output logic [N_OBJ*COORD_W-1:0]   out_x1,
    output logic [N_OBJ*COORD_W-1:0]   out_x2,
    output logic [N_OBJ*COORD_W-1:0]   out_y1,
    output logic [N_OBJ*COORD_W-1:0]   out_y2
);

    localparam logic [COORD_W-1:0] X_MIN = COORD_W'(axis_min(H_SIZE));
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(axis_max(D_WIDTH, H_SIZE));
    localparam logic [COORD_W-1:0] Y_MIN = COORD_W'(axis_min(V_SIZE));
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(axis_max(D_HEIGHT, V_SIZE));
    localparam logic [COORD_W-1:0] X_RST = COORD_W'(D_WIDTH / 2);
    localparam logic [COORD_W-1:0] Y_RST = COORD_W'(D_HEIGHT / 2);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_OBJ - 1);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [N_OBJ-1:0]          bounce_q, bounce_d;
    logic                      overrun_q, overrun_d;
    logic [COORD_W-1:0]        x_q [N_OBJ];
    logic [COORD_W-1:0]        x_d [N_OBJ];
    logic [COORD_W-1:0]        y_q [N_OBJ];
    logic [COORD_W-1:0]        y_d [N_OBJ];
    logic signed [STEP_W-1:0]  vx_q [N_OBJ];
    logic signed [STEP_W-1:0]  vx_d [N_OBJ];
    logic signed [STEP_W-1:0]  vy_q [N_OBJ];
    logic signed [STEP_W-1:0]  vy_d [N_OBJ];

    logic [COORD_W-1:0]        nx, ny;
    logic signed [STEP_W-1:0]  nvx, nvy;
    logic                      bx, by;
    logic                      cfg_valid;
    logic [COORD_W-1:0]        cfg_x_clamped, cfg_y_clamped;

    object_axis_step #(.COORD_W(COORD_W), .STEP_W(STEP_W)) u_step_x (
        .in_p(x_q[idx_q]), .in_v(vx_q[idx_q]), .in_min(X_MIN), .in_max(X_MAX),
        .out_p(nx), .out_v(nvx), .out_bounce(bx)
    );

    object_axis_step #(.COORD_W(COORD_W), .STEP_W(STEP_W)) u_step_y (
        .in_p(y_q[idx_q]), .in_v(vy_q[idx_q]), .in_min(Y_MIN), .in_max(Y_MAX),
        .out_p(ny), .out_v(nvy), .out_bounce(by)
    );

    assign cfg_valid = in_cfg_we && (int'(in_cfg_idx) < N_OBJ);

    always_comb begin
        cfg_x_clamped = in_cfg_x;
        if (in_cfg_x < X_MIN) cfg_x_clamped = X_MIN;
        else if (in_cfg_x > X_MAX) cfg_x_clamped = X_MAX;
        cfg_y_clamped = in_cfg_y;
        if (in_cfg_y < Y_MIN) cfg_y_clamped = Y_MIN;
        else if (in_cfg_y > Y_MAX) cfg_y_clamped = Y_MAX;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bounce_d  = bounce_q;
        overrun_d = overrun_q;
        x_d       = x_q;
        y_d       = y_q;
        vx_d      = vx_q;
        vy_d      = vy_q;

        case (state_q)
            ST_IDLE: begin
                if (in_ani_stb && in_animate) begin
                    state_d  = ST_RUN;
                    idx_d    = '0;
                    bounce_d = '0;
                end
            end
            ST_RUN: begin
                // A config write to the object under update takes priority.
                if (!(cfg_valid && in_cfg_idx == idx_q)) begin
                    x_d[idx_q]      = nx;
                    y_d[idx_q]      = ny;
                    vx_d[idx_q]     = nvx;
                    vy_d[idx_q]     = nvy;
                    bounce_d[idx_q] = bx | by;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (in_ani_stb && state_q != ST_IDLE) overrun_d = 1'b1;

        if (cfg_valid) begin
            x_d[in_cfg_idx]  = cfg_x_clamped;
            y_d[in_cfg_idx]  = cfg_y_clamped;
            vx_d[in_cfg_idx] = STEP_W'(sat_vel(32'(in_cfg_vx), STEP_W));
            vy_d[in_cfg_idx] = STEP_W'(sat_vel(32'(in_cfg_vy), STEP_W));
        end
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            bounce_q  <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N_OBJ; i++) begin
                x_q[i]  <= X_RST;
                y_q[i]  <= Y_RST;
                vx_q[i] <= '0;
                vy_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            bounce_q  <= bounce_d;
            overrun_q <= overrun_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
        end
    end

    assign out_busy       = (state_q != ST_IDLE);
    assign out_frame_done = (state_q == ST_DONE);
    assign out_bounce     = bounce_q;
    assign out_overrun    = overrun_q;

    for (genvar g = 0; g < N_OBJ; g++) begin : g_edges
        assign out_x1[g*COORD_W +: COORD_W] = x_q[g] - COORD_W'(H_SIZE);
        assign out_x2[g*COORD_W +: COORD_W] = x_q[g] + COORD_W'(H_SIZE);
        assign out_y1[g*COORD_W +: COORD_W] = y_q[g] - COORD_W'(V_SIZE);
        assign out_y2[g*COORD_W +: COORD_W] = y_q[g] + COORD_W'(V_SIZE);
    end

endmodule

// File: tb/tb_object_bank.sv
// Self-checking bench for object_bank: scenario tasks plus a frame scoreboard
// that is checked whenever frame_done is seen.
module tb_object_bank;

    localparam int N  = 4;
    localparam int CW = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ani_stb, animate, cfg_we;
    logic [1:0]      cfg_idx;
    logic [CW-1:0]   cfg_x, cfg_y;
    logic signed [4:0] cfg_vx, cfg_vy;
    logic            busy, frame_done, overrun;
    logic [N-1:0]    bounce;
    logic [N*CW-1:0] x1, x2, y1, y2;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int         obj;
        logic [11:0] x;
        logic [11:0] y;
        logic        bnc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int mx[N], my[N], mvx[N], mvy[N];

    always #5 clk = ~clk;

    object_bank dut (
        .in_clock(clk), .in_reset_n(rst_n), .in_ani_stb(ani_stb), .in_animate(animate),
        .in_cfg_we(cfg_we), .in_cfg_idx(cfg_idx), .in_cfg_x(cfg_x), .in_cfg_y(cfg_y),
        .in_cfg_vx(cfg_vx), .in_cfg_vy(cfg_vy), .out_busy(busy), .out_frame_done(frame_done),
        .out_bounce(bounce), .out_overrun(overrun), .out_x1(x1), .out_x2(x2),
        .out_y1(y1), .out_y2(y2)
    );

    // Scoreboard consumer: a finished frame must match the model for every object.
    always @(negedge clk) begin
        if (rst_n && frame_done) begin
            if (sb_q.size() < N) begin
                tests_run++;
                tests_failed++;
                $display("FAIL sb_frame: frame_done with %0d queued entries, need %0d", sb_q.size(), N);
            end else begin
                for (int i = 0; i < N; i++) begin
                    mon_e = sb_q.pop_front();
                    tests_run++;
                    if (x1[mon_e.obj*CW +: CW] !== mon_e.x - 12'd10 || x2[mon_e.obj*CW +: CW] !== mon_e.x + 12'd10 ||
                        y1[mon_e.obj*CW +: CW] !== mon_e.y - 12'd10 || y2[mon_e.obj*CW +: CW] !== mon_e.y + 12'd10 ||
                        bounce[mon_e.obj] !== mon_e.bnc) begin
                        tests_failed++;
                        $display("FAIL sb_obj%0d: got x1=%0d y1=%0d bnc=%b, want x1=%0d y1=%0d bnc=%b",
                                 mon_e.obj, x1[mon_e.obj*CW +: CW], y1[mon_e.obj*CW +: CW], bounce[mon_e.obj],
                                 mon_e.x - 12'd10, mon_e.y - 12'd10, mon_e.bnc);
                    end
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = 320; my[i] = 240; mvx[i] = 0; mvy[i] = 0;
        end
    endtask

    task automatic model_write(input int i, input int x, input int y, input int vx, input int vy);
        mx[i]  = (x < 10) ? 10 : (x > 629) ? 629 : x;
        my[i]  = (y < 10) ? 10 : (y > 469) ? 469 : y;
        mvx[i] = (vx == -16) ? -15 : vx;
        mvy[i] = (vy == -16) ? -15 : vy;
    endtask

    task automatic model_axis(input int p, input int v, input int lo, input int hi,
                              output int np, output int nv, output bit b);
        np = p + v; nv = v; b = 1'b0;
        if (np < lo) begin np = lo; nv = -v; b = 1'b1; end
        else if (np > hi) begin np = hi; nv = -v; b = 1'b1; end
    endtask

    task automatic model_frame(input logic [N-1:0] skip);
        exp_t e;
        int nx, nvx, ny, nvy;
        bit bx, by;
        for (int i = 0; i < N; i++) begin
            e.obj = i;
            e.bnc = 1'b0;
            if (!skip[i]) begin
                model_axis(mx[i], mvx[i], 10, 629, nx, nvx, bx);
                model_axis(my[i], mvy[i], 10, 469, ny, nvy, by);
                mx[i] = nx; mvx[i] = nvx; my[i] = ny; mvy[i] = nvy;
                e.bnc = bx | by;
            end
            e.x = 12'(mx[i]);
            e.y = 12'(my[i]);
            sb_q.push_back(e);
        end
    endtask

    task automatic cfg_write(input int i, input int x, input int y, input int vx, input int vy);
        cfg_we = 1'b1; cfg_idx = 2'(i); cfg_x = 12'(x); cfg_y = 12'(y);
        cfg_vx = 5'(vx); cfg_vy = 5'(vy);
        model_write(i, x, y, vx, vy);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_frame(output int cyc);
        model_frame('0);
        ani_stb = 1'b1;
        @(posedge clk); #1;
        ani_stb = 1'b0;
        cyc = 1;
        while (!frame_done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (x1[i*CW +: CW] !== 12'd310 || x2[i*CW +: CW] !== 12'd330 ||
                y1[i*CW +: CW] !== 12'd230 || y2[i*CW +: CW] !== 12'd250) begin
                tests_failed++;
                $display("FAIL reset_edges%0d: got %0d %0d %0d %0d, want 310 330 230 250", i,
                         x1[i*CW +: CW], x2[i*CW +: CW], y1[i*CW +: CW], y2[i*CW +: CW]);
            end
        end
        tests_run++;
        if ({busy, overrun, frame_done, bounce} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got busy=%b ovr=%b done=%b bnc=%b, want all zero",
                     busy, overrun, frame_done, bounce);
        end
    endtask

    task automatic test_basic();
        int cyc;
        cfg_write(0, 100, 100, 3, -2);
        do_frame(cyc);
        tests_run++;
        if (cyc !== 5) begin
            tests_failed++;
            $display("FAIL basic_latency: frame_done in cycle %0d, want 5", cyc);
        end
        tests_run++;
        if (x1[0 +: CW] !== 12'd93 || y1[0 +: CW] !== 12'd88) begin
            tests_failed++;
            $display("FAIL basic_obj0: got x1=%0d y1=%0d, want 93 88", x1[0 +: CW], y1[0 +: CW]);
        end
        for (int i = 1; i < N; i++) begin
            tests_run++;
            if (x1[i*CW +: CW] !== 12'd310 || y1[i*CW +: CW] !== 12'd230) begin
                tests_failed++;
                $display("FAIL basic_unchanged%0d: got x1=%0d y1=%0d, want 310 230", i,
                         x1[i*CW +: CW], y1[i*CW +: CW]);
            end
        end
    endtask

    task automatic test_left_bounce();
        int cyc;
        cfg_write(1, 12, 240, -5, 0);
        do_frame(cyc);
        tests_run++;
        if (x1[CW +: CW] !== 12'd0 || bounce[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL left_bounce: got x1=%0d bnc=%b, want 0 1", x1[CW +: CW], bounce[1]);
        end
        do_frame(cyc);
        tests_run++;
        if (x1[CW +: CW] !== 12'd5 || bounce[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL left_rebound: got x1=%0d bnc=%b, want 5 0", x1[CW +: CW], bounce[1]);
        end
    endtask

    task automatic test_right_bottom();
        int cyc;
        cfg_write(2, 628, 467, 4, 5);
        do_frame(cyc);
        tests_run++;
        if (x2[2*CW +: CW] !== 12'd639 || y2[2*CW +: CW] !== 12'd479 || bounce[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL right_bottom_clamp: got x2=%0d y2=%0d bnc=%b, want 639 479 1",
                     x2[2*CW +: CW], y2[2*CW +: CW], bounce[2]);
        end
        do_frame(cyc);
        tests_run++;
        if (x2[2*CW +: CW] !== 12'd635 || y2[2*CW +: CW] !== 12'd474) begin
            tests_failed++;
            $display("FAIL right_bottom_negate: got x2=%0d y2=%0d, want 635 474",
                     x2[2*CW +: CW], y2[2*CW +: CW]);
        end
    endtask

    task automatic test_cfg_clamp_sat();
        int cyc;
        cfg_write(3, 2000, 0, -16, 0);
        tests_run++;
        if (x2[3*CW +: CW] !== 12'd639 || y1[3*CW +: CW] !== 12'd0) begin
            tests_failed++;
            $display("FAIL cfg_clamp: got x2=%0d y1=%0d, want 639 0", x2[3*CW +: CW], y1[3*CW +: CW]);
        end
        do_frame(cyc);
        tests_run++;
        if (x1[3*CW +: CW] !== 12'd604) begin
            tests_failed++;
            $display("FAIL cfg_vel_sat: got x1=%0d, want 604", x1[3*CW +: CW]);
        end
    endtask

    task automatic test_mid_frame_write();
        int cyc;
        model_write(0, 200, 200, 1, 1);
        model_write(3, 300, 300, 2, 0);
        model_frame(4'b0001);
        ani_stb = 1'b1;
        @(posedge clk); #1;
        ani_stb = 1'b0;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_x = 12'd200; cfg_y = 12'd200; cfg_vx = 5'sd1; cfg_vy = 5'sd1;
        @(posedge clk); #1;
        cfg_idx = 2'd3; cfg_x = 12'd300; cfg_y = 12'd300; cfg_vx = 5'sd2; cfg_vy = 5'sd0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        cyc = 0;
        while (!frame_done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests_run++;
        if (cyc >= 20) begin
            tests_failed++;
            $display("FAIL mid_done_timeout: no frame_done after %0d cycles, want within 20", cyc);
        end
        @(posedge clk); #1;
        tests_run++;
        if (x1[0 +: CW] !== 12'd190 || y1[0 +: CW] !== 12'd190) begin
            tests_failed++;
            $display("FAIL mid_write_wins: got x1=%0d y1=%0d, want 190 190", x1[0 +: CW], y1[0 +: CW]);
        end
        tests_run++;
        if (x1[3*CW +: CW] !== 12'd292) begin
            tests_failed++;
            $display("FAIL mid_write_ahead: got x1=%0d, want 292", x1[3*CW +: CW]);
        end
    endtask

    task automatic test_overrun();
        int dones = 0;
        model_frame('0);
        ani_stb = 1'b1;
        @(posedge clk); #1;
        ani_stb = 1'b0;
        @(posedge clk); #1;
        ani_stb = 1'b1;
        @(posedge clk); #1;
        ani_stb = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (frame_done) dones++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (dones !== 1 || overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun: got dones=%0d ovr=%b, want 1 1", dones, overrun);
        end
        animate = 1'b0;
        ani_stb = 1'b1;
        @(posedge clk); #1;
        ani_stb = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_animate: got busy=%b, want 0", busy);
        end
        animate = 1'b1;
    endtask

    task automatic test_reset_mid();
        ani_stb = 1'b1;
        @(posedge clk); #1;
        ani_stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || overrun !== 1'b0 || bounce !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_ctrl: got busy=%b ovr=%b bnc=%b, want 0 0 0", busy, overrun, bounce);
        end
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (x1[i*CW +: CW] !== 12'd310 || y2[i*CW +: CW] !== 12'd250) begin
                tests_failed++;
                $display("FAIL reset_mid_obj%0d: got x1=%0d y2=%0d, want 310 250", i,
                         x1[i*CW +: CW], y2[i*CW +: CW]);
            end
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; ani_stb = 1'b0; animate = 1'b1; cfg_we = 1'b0;
        cfg_idx = '0; cfg_x = '0; cfg_y = '0; cfg_vx = '0; cfg_vy = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_left_bounce();
        test_right_bottom();
        test_cfg_clamp_sat();
        test_mid_frame_write();
        test_overrun();
        test_reset_mid();
        tests_run++;
        if (sb_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: %0d expected entries never consumed, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
